// File: rtl/mmc1_serial_ctrl.sv
// MMC1 serial bank-register loader: gathers five LSB-first data bits per register write,
// commits them to control/CHR0/CHR1/PRG and decodes the registers onto cartridge address lines.
module mmc1_serial_ctrl #(
   parameter logic [4:0] CTRL_RESET    = 5'h0C,
   parameter bit         CONSEC_FILTER = 1'b1
) (
   input  logic       ck,
   input  logic       res,
   input  logic       wr_stb,
   input  logic       cpu_a14,
   input  logic       cpu_a13,
   input  logic       cpu_d0,
   input  logic       cpu_d7,
   input  logic       ppu_a12,
   input  logic       ppu_a11,
   input  logic       ppu_a10,
   output logic       upd,
   output logic [4:0] ctrl_q,
   output logic [4:0] chr0_q,
   output logic [4:0] chr1_q,
   output logic [4:0] prg_q,
   output logic [3:0] prg_a,
   output logic [4:0] chr_a,
   output logic       ciram_a10,
   output logic       prg_ram_ce_n
);

   // wr_stb is a bare one-cycle strobe with no back-pressure: every accepted strobe is
   // consumed in the cycle it is seen, and upd reports a commit one cycle later.
   logic [3:0] sr_q, sr_d;
   logic [2:0] cnt_q, cnt_d;
   logic       last_q, last_d;
   logic       upd_q, upd_d;
   logic [4:0] ctrl_d, chr0_d, chr1_d, prg_d;
   logic       accept;
   logic [4:0] value;

   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      last_d = wr_stb;
      upd_d  = 1'b0;
      ctrl_d = ctrl_q;
      chr0_d = chr0_q;
      chr1_d = chr1_q;
      prg_d  = prg_q;
      value  = {cpu_d0, sr_q};
      // A read-modify-write instruction issues two strobes back to back; only the first counts.
      accept = wr_stb & ~(CONSEC_FILTER & last_q);
      if (accept) begin
         if (cpu_d7) begin
            sr_d   = 4'h0;
            cnt_d  = 3'd0;
            ctrl_d = ctrl_q | CTRL_RESET;
         end else if (cnt_q < 3'd4) begin
            sr_d  = {cpu_d0, sr_q[3:1]};
            cnt_d = cnt_q + 3'd1;
         end else begin
            unique case ({cpu_a14, cpu_a13})
               2'b00:   ctrl_d = value;
               2'b01:   chr0_d = value;
               2'b10:   chr1_d = value;
               default: prg_d  = value;
            endcase
            sr_d  = 4'h0;
            cnt_d = 3'd0;
            upd_d = 1'b1;
         end
      end
   end

   always_ff @(posedge ck) begin
      if (res) begin
         sr_q   <= 4'h0;
         cnt_q  <= 3'd0;
         last_q <= 1'b0;
         upd_q  <= 1'b0;
         ctrl_q <= CTRL_RESET;
         chr0_q <= 5'h00;
         chr1_q <= 5'h00;
         prg_q  <= 5'h00;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
         upd_q  <= upd_d;
         ctrl_q <= ctrl_d;
         chr0_q <= chr0_d;
         chr1_q <= chr1_d;
         prg_q  <= prg_d;
      end
   end

   assign upd          = upd_q;
   assign prg_ram_ce_n = prg_q[4];

   always_comb begin
      unique case (ctrl_q[1:0])
         2'd0:    ciram_a10 = 1'b0;
         2'd1:    ciram_a10 = 1'b1;
         2'd2:    ciram_a10 = ppu_a10;
         default: ciram_a10 = ppu_a11;
      endcase

      // Modes 0/1 switch 32 KiB; mode 2 fixes the first bank low, mode 3 fixes the last bank high.
      unique case (ctrl_q[3:2])
         2'd0, 2'd1: prg_a = {prg_q[3:1], cpu_a14};
         2'd2:       prg_a = cpu_a14 ? prg_q[3:0] : 4'h0;
         default:    prg_a = cpu_a14 ? 4'hF : prg_q[3:0];
      endcase

      if (ctrl_q[4]) chr_a = ppu_a12 ? chr1_q : chr0_q;
      else           chr_a = {chr0_q[4:1], ppu_a12};
   end

endmodule

// File: tb/tb_mmc1_serial_ctrl.sv
// Bench for mmc1_serial_ctrl: a filtered and an unfiltered instance share one bus and are
// compared every cycle against a bit-accumulating reference model, plus table and corner sequences.
module tb_mmc1_serial_ctrl;

   logic ck = 1'b0;
   logic res = 1'b0, wr_stb = 1'b0, cpu_a14 = 1'b0, cpu_a13 = 1'b0, cpu_d0 = 1'b0, cpu_d7 = 1'b0;
   logic ppu_a12 = 1'b0, ppu_a11 = 1'b0, ppu_a10 = 1'b0;

   logic       upd0, upd1, cir0, cir1, ce0, ce1;
   logic [4:0] ctrl0, ctrl1, chr0_0, chr0_1, chr1_0, chr1_1, prg0, prg1, chra0, chra1;
   logic [3:0] prga0, prga1;

   int checks = 0;
   int errors = 0;
   int upd_seen = 0;

   always #5 ck = ~ck;

   mmc1_serial_ctrl #(.CTRL_RESET(5'h0C), .CONSEC_FILTER(1'b1)) dut (
      .ck(ck), .res(res), .wr_stb(wr_stb), .cpu_a14(cpu_a14), .cpu_a13(cpu_a13),
      .cpu_d0(cpu_d0), .cpu_d7(cpu_d7), .ppu_a12(ppu_a12), .ppu_a11(ppu_a11), .ppu_a10(ppu_a10),
      .upd(upd0), .ctrl_q(ctrl0), .chr0_q(chr0_0), .chr1_q(chr1_0), .prg_q(prg0),
      .prg_a(prga0), .chr_a(chra0), .ciram_a10(cir0), .prg_ram_ce_n(ce0));

   mmc1_serial_ctrl #(.CTRL_RESET(5'h0C), .CONSEC_FILTER(1'b0)) dut_nf (
      .ck(ck), .res(res), .wr_stb(wr_stb), .cpu_a14(cpu_a14), .cpu_a13(cpu_a13),
      .cpu_d0(cpu_d0), .cpu_d7(cpu_d7), .ppu_a12(ppu_a12), .ppu_a11(ppu_a11), .ppu_a10(ppu_a10),
      .upd(upd1), .ctrl_q(ctrl1), .chr0_q(chr0_1), .chr1_q(chr1_1), .prg_q(prg1),
      .prg_a(prga1), .chr_a(chra1), .ciram_a10(cir1), .prg_ram_ce_n(ce1));

   // Reference model: index 0 filtered, index 1 unfiltered.
   int m_ctrl[2], m_chr0[2], m_chr1[2], m_prg[2], m_n[2], m_val[2];
   bit m_last[2], m_upd[2];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input int k);
      bit acc;
      m_upd[k] = 1'b0;
      if (res) begin
         m_ctrl[k] = 'h0C; m_chr0[k] = 0; m_chr1[k] = 0; m_prg[k] = 0;
         m_n[k] = 0; m_val[k] = 0; m_last[k] = 1'b0;
      end else begin
         acc = wr_stb && !((k == 0) && m_last[k]);
         if (acc) begin
            if (cpu_d7) begin
               m_n[k] = 0; m_val[k] = 0;
               m_ctrl[k] = m_ctrl[k] | 'h0C;
            end else begin
               m_val[k] = m_val[k] + (int'(cpu_d0) << m_n[k]);
               m_n[k]++;
               if (m_n[k] == 5) begin
                  case ({cpu_a14, cpu_a13})
                     2'b00:   m_ctrl[k] = m_val[k];
                     2'b01:   m_chr0[k] = m_val[k];
                     2'b10:   m_chr1[k] = m_val[k];
                     default: m_prg[k]  = m_val[k];
                  endcase
                  m_n[k] = 0; m_val[k] = 0; m_upd[k] = 1'b1;
               end
            end
         end
         m_last[k] = wr_stb;
      end
   endtask

   task automatic check_dut(input int k);
      int mode_m, mode_p, e_cir, e_prga, e_chra;
      mode_m = m_ctrl[k] % 4;
      mode_p = (m_ctrl[k] / 4) % 4;
      case (mode_m)
         0: e_cir = 0;
         1: e_cir = 1;
         2: e_cir = int'(ppu_a10);
         default: e_cir = int'(ppu_a11);
      endcase
      case (mode_p)
         0, 1: e_prga = (m_prg[k] % 16) - (m_prg[k] % 2) + int'(cpu_a14);
         2: e_prga = cpu_a14 ? m_prg[k] % 16 : 0;
         default: e_prga = cpu_a14 ? 15 : m_prg[k] % 16;
      endcase
      if (m_ctrl[k] >= 16) e_chra = ppu_a12 ? m_chr1[k] : m_chr0[k];
      else e_chra = m_chr0[k] - (m_chr0[k] % 2) + int'(ppu_a12);
      chk($sformatf("d%0d_upd", k), int'(k == 0 ? upd0 : upd1), int'(m_upd[k]));
      chk($sformatf("d%0d_ctrl", k), int'(k == 0 ? ctrl0 : ctrl1), m_ctrl[k]);
      chk($sformatf("d%0d_chr0", k), int'(k == 0 ? chr0_0 : chr0_1), m_chr0[k]);
      chk($sformatf("d%0d_chr1", k), int'(k == 0 ? chr1_0 : chr1_1), m_chr1[k]);
      chk($sformatf("d%0d_prg", k), int'(k == 0 ? prg0 : prg1), m_prg[k]);
      chk($sformatf("d%0d_prg_a", k), int'(k == 0 ? prga0 : prga1), e_prga);
      chk($sformatf("d%0d_chr_a", k), int'(k == 0 ? chra0 : chra1), e_chra);
      chk($sformatf("d%0d_ciram", k), int'(k == 0 ? cir0 : cir1), e_cir);
      chk($sformatf("d%0d_ram_ce_n", k), int'(k == 0 ? ce0 : ce1), m_prg[k] / 16);
   endtask

   task automatic cycle(input bit r, input bit w, input bit [1:0] sel, input bit d0, input bit d7);
      res = r; wr_stb = w; cpu_a14 = sel[1]; cpu_a13 = sel[0]; cpu_d0 = d0; cpu_d7 = d7;
      @(posedge ck);
      model_step(0);
      model_step(1);
      #1;
      if (upd0) upd_seen++;
      check_dut(0);
      check_dut(1);
   endtask

   task automatic write_bit(input bit [1:0] sel, input bit d0);
      cycle(1'b0, 1'b1, sel, d0, 1'b0);
      cycle(1'b0, 1'b0, sel, 1'b0, 1'b0);
   endtask

   task automatic write_reg(input bit [1:0] sel, input bit [4:0] val);
      for (int i = 0; i < 5; i++) write_bit(sel, val[i]);
   endtask

   typedef struct {
      bit       res;
      bit       wr;
      bit [1:0] sel;
      bit       d0;
      bit       e_upd;
      bit [4:0] e_ctrl;
      bit [4:0] e_prg;
      bit [3:0] e_prga;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // Reset, then five spaced writes 1,0,1,1,0 to $E000 (PRG), checked cycle by cycle.
      tbl[0]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 5'h0C, 5'h00, 4'hF};
      tbl[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'h0C, 5'h00, 4'h0};
      tbl[2]  = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 5'h0C, 5'h00, 4'hF};
      tbl[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'h0C, 5'h00, 4'h0};
      tbl[4]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 5'h0C, 5'h00, 4'hF};
      tbl[5]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'h0C, 5'h00, 4'h0};
      tbl[6]  = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 5'h0C, 5'h00, 4'hF};
      tbl[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'h0C, 5'h00, 4'h0};
      tbl[8]  = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 5'h0C, 5'h00, 4'hF};
      tbl[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'h0C, 5'h00, 4'h0};
      tbl[10] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 5'h0C, 5'h0D, 4'hF};
      tbl[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'h0C, 5'h0D, 4'hD};

      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].res, tbl[i].wr, tbl[i].sel, tbl[i].d0, 1'b0);
         chk($sformatf("tbl%0d_upd", i), int'(upd0), int'(tbl[i].e_upd));
         chk($sformatf("tbl%0d_ctrl", i), int'(ctrl0), int'(tbl[i].e_ctrl));
         chk($sformatf("tbl%0d_prg", i), int'(prg0), int'(tbl[i].e_prg));
         chk($sformatf("tbl%0d_prg_a", i), int'(prga0), int'(tbl[i].e_prga));
      end

      // Partial bits discarded by a bit-7 write, then a full load of 0x1F into CHR0.
      cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) write_bit(2'b01, 1'b1);
      cycle(1'b0, 1'b1, 2'b00, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("d7_ctrl_kept", int'(ctrl0), 'h0C);
      write_bit(2'b01, 1'b1);
      write_bit(2'b01, 1'b1);
      chk("d7_no_early_commit", int'(chr0_0), 0);
      for (int i = 0; i < 3; i++) write_bit(2'b01, 1'b1);
      chk("d7_chr0", int'(chr0_0), 'h1F);

      // Back-to-back strobes: filtered instance counts one, unfiltered counts two.
      cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) write_bit(2'b10, 1'b0);
      chk("rmw_filt_pending", int'(chr1_0), 0);
      chk("rmw_nofilt_chr1", int'(chr1_1), 3);
      write_bit(2'b10, 1'b0);
      chk("rmw_filt_chr1", int'(chr1_0), 1);
      chk("rmw_nofilt_hold", int'(chr1_1), 3);

      // CHR decode in 4 KiB and 8 KiB modes.
      cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      write_reg(2'b01, 5'h05);
      write_reg(2'b10, 5'h0A);
      write_reg(2'b00, 5'h10);
      ppu_a12 = 1'b0; cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("chr4k_lo", int'(chra0), 'h05);
      ppu_a12 = 1'b1; cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("chr4k_hi", int'(chra0), 'h0A);
      write_reg(2'b00, 5'h00);
      ppu_a12 = 1'b0; cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("chr8k_lo", int'(chra0), 'h04);
      ppu_a12 = 1'b1; cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("chr8k_hi", int'(chra0), 'h05);

      // Reset mid-sequence, then load 0x1F into control; mirroring follows ppu_a11.
      cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) write_bit(2'b00, 1'b1);
      cycle(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
      upd_seen = 0;
      write_reg(2'b00, 5'h1F);
      chk("rst_mid_ctrl", int'(ctrl0), 'h1F);
      chk("rst_mid_upd_count", upd_seen, 1);
      ppu_a11 = 1'b0; ppu_a10 = 1'b1; cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("ciram_a11_lo", int'(cir0), 0);
      ppu_a11 = 1'b1; ppu_a10 = 1'b0; cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      chk("ciram_a11_hi", int'(cir0), 1);

      // Randomized traffic against the model for both filter settings.
      for (int i = 0; i < 800; i++) begin
         ppu_a12 = 1'($urandom_range(0, 1));
         ppu_a11 = 1'($urandom_range(0, 1));
         ppu_a10 = 1'($urandom_range(0, 1));
         cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
